i2c_cmd_sequencer: RTL and testbench
====================================

Name: i2c_cmd_sequencer

Overview:
Table-free, host-driven command sequencer that sits directly upstream of i2c_master_logic. It replaces hard-wired per-state configuration with a command FIFO. Each queued command is presented to the master as config/device/register/data fields, held until the transfer completes, and read bytes are returned on a valid strobe. It runs on the 12 MHz system clock. The completion flag comes from the I2C clock domain and is synchronised internally.

Parameters:
DEPTH, 8, command FIFO entries (power of two, 2..32)
GAP_CYC, 1200, clk_12m cycles with config forced to Wait between commands (100 us)
TIMEOUT_CYC, 1200000, clk_12m cycles allowed per command before abort (100 ms)

Ports:
clk_12m  in  1  system clock, 12 MHz
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  push request
cmd_ready  out  1  FIFO not full
cmd_op  in  8  I2C mode code (shared package constants)
cmd_dev  in  7  7-bit device address
cmd_reg  in  8  register address
cmd_data  in  8  write data
enable  in  1  1 = issue queued commands
i2c_done_async  in  1  i2c_clk-domain completion flag (i2c_ack[2] | i2c_ack[5])
i2c_read_data  in  8  byte read by master
i2c_config  out  8  mode to master
i2c_dev_addr  out  7  to master
i2c_reg_addr  out  8  to master
i2c_reg_data  out  8  to master
rd_valid  out  1  one-cycle strobe, rd_data valid
rd_data  out  8  captured read byte
busy  out  1  state != IDLE
fifo_count  out  $clog2(DEPTH)+1  entries queued
err_timeout  out  1  sticky, command aborted on timeout
err_illegal  out  1  sticky, unsupported op dropped
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (async, rst=1): FIFO empty; i2c_config=0x00 (Wait); dev/reg/data outputs 0; rd_valid=0; rd_data=0; errors 0; state IDLE; sync flops 0.
- FIFO: a push happens when cmd_valid & cmd_ready. An entry is 31 bits {op, dev, reg, data}. Pointers are binary and wrap modulo DEPTH. When the FIFO is full, cmd_ready=0 and the push is ignored. When push and pop occur in the same cycle, the count is unchanged. This is allowed even when full, because the pop frees the slot.
- Done sync: i2c_done_async passes through a 2-flop synchroniser and a third flop. done_rise = s2 & ~s3, which detects rising edges only.
- FSM:
  - IDLE: if enable and FIFO is non-empty, pop the head.
    - If op is in {01 single write, 03 write direct, 04 single read, 06 read direct}: load i2c_config/dev/reg/data next cycle, clear the timer, go to BUSY.
    - If op is anything else: set err_illegal, discard the entry, stay in IDLE (one entry per cycle).
  - BUSY: outputs are held stable and the timer increments.
    - On done_rise: if op is 04 or 06, rd_data <= i2c_read_data and rd_valid=1 for one cycle. Then i2c_config <= 0x00, load the gap counter with GAP_CYC-1, go to GAP.
    - Else if timer == TIMEOUT_CYC-1: set err_timeout, i2c_config <= 0x00, go to GAP with no rd_valid.
    - done_rise takes priority over timeout in the same cycle.
  - GAP: i2c_config=0x00. Count down; at 0 go to IDLE. done_rise is ignored here.
- Latency: the first command reaches i2c_config 2 cycles after the push, i.e. the push registers and then IDLE pops. The next command is issued no earlier than GAP_CYC+1 cycles after completion.
- Deasserting enable only blocks pops in IDLE. An in-flight command still completes.
- dev/reg/data outputs keep their last value after completion. Only i2c_config returns to Wait.
- err_clr clears both sticky errors. If an error event occurs in the same cycle, the set wins.
- Reset asserted mid-command returns everything to reset values immediately. Queued commands are lost.

Decomposition:
- Shared package i2c_pkg:
  - mode constants I2C_WAIT=0x00, I2C_SINGLE_WRITE=0x01, I2C_CONT_WRITE=0x02, I2C_WRITE_DIRECT=0x03, I2C_SINGLE_READ=0x04, I2C_CONT_READ=0x05, I2C_READ_DIRECT=0x06
  - FSM state encoding IDLE/BUSY/GAP
  - command-word field offsets
- One sub-module, i2c_cmd_fifo: synchronous FIFO with parameter DEPTH and ports push/pop/full/empty/count. The synchroniser stays inline.

Test Plan:
- Single write: push {01,0x50,0x00,0x11}, enable=1 → i2c_config=0x01, dev=0x50, reg=0x00, data=0x11 at cycle +2. Pulse done → config=0x00 within 4 cycles. No rd_valid. busy drops after GAP_CYC.
- Write then read: push {01,0x50,0x00,0x11} then {04,0x50,0x00,xx}. Model returns 0x11 on the second done → rd_valid one cycle with rd_data=0x11. The second command is issued ≥GAP_CYC cycles after the first done.
- Full FIFO: enable=0, push 9 commands → cmd_ready=0 after 8, fifo_count=8, 9th dropped. Enable → exactly 8 commands issued in order.
- Illegal op: push {02,...} then {03,0x50,0x10,0xAA} → err_illegal=1, first dropped, config=0x03 next. err_clr → err_illegal=0.
- Timeout (TIMEOUT_CYC=100 in sim): issue 04 with no done → err_timeout=1 at cycle 100, config=0x00, no rd_valid, next command proceeds.
- Reset mid-BUSY: rst=1 during a read → all outputs 0 asynchronously and fifo_count=0. After release, a late done pulse produces no rd_valid.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C mode codes, sequencer state encoding and command-word layout
// used by the command sequencer and its FIFO.
package i2c_pkg;

  localparam logic [7:0] I2C_WAIT         = 8'h00;
  localparam logic [7:0] I2C_SINGLE_WRITE = 8'h01;
  localparam logic [7:0] I2C_CONT_WRITE   = 8'h02;
  localparam logic [7:0] I2C_WRITE_DIRECT = 8'h03;
  localparam logic [7:0] I2C_SINGLE_READ  = 8'h04;
  localparam logic [7:0] I2C_CONT_READ    = 8'h05;
  localparam logic [7:0] I2C_READ_DIRECT  = 8'h06;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

  // Command word is {op[7:0], dev[6:0], reg[7:0], data[7:0]}.
  localparam int unsigned CMD_W    = 31;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned DEV_LSB  = 16;
  localparam int unsigned OP_LSB   = 23;

  function automatic logic op_is_read(input logic [7:0] op);
    return (op == I2C_SINGLE_READ) || (op == I2C_READ_DIRECT);
  endfunction

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op == I2C_SINGLE_WRITE) || (op == I2C_WRITE_DIRECT) || op_is_read(op);
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with binary pointers wrapping modulo DEPTH.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module i2c_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Host-driven command sequencer feeding i2c_master_logic: pops queued commands,
// holds them on the master interface until done, returns read bytes, enforces gap/timeout.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned GAP_CYC     = 1200,
  parameter int unsigned TIMEOUT_CYC = 1200000
) (
  input  logic                   clk_12m,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_op,
  input  logic [6:0]             cmd_dev,
  input  logic [7:0]             cmd_reg,
  input  logic [7:0]             cmd_data,
  input  logic                   enable,
  input  logic                   i2c_done_async,
  input  logic [7:0]             i2c_read_data,
  output logic [7:0]             i2c_config,
  output logic [6:0]             i2c_dev_addr,
  output logic [7:0]             i2c_reg_addr,
  output logic [7:0]             i2c_reg_data,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_timeout,
  output logic                   err_illegal,
  input  logic                   err_clr
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  seq_state_e       state_q;
  logic [TW-1:0]    timer_q;
  logic [GW-1:0]    gap_q;
  logic             is_read_q;
  logic [7:0]       config_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic [7:0]       data_q;
  logic             rd_valid_q;
  logic [7:0]       rd_data_q;
  logic             err_timeout_q;
  logic             err_illegal_q;
  logic             done_s1_q, done_s2_q, done_s3_q;
  logic             done_rise;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [CMD_W-1:0] push_word, head;
  logic [7:0]       head_op;

  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign push_word = {cmd_op, cmd_dev, cmd_reg, cmd_data};
  assign pop       = (state_q == IDLE) & enable & ~fifo_empty;
  assign head_op   = head[OP_LSB +: 8];

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk_12m),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_word),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Two flops cross from the i2c clock domain; the third gives rising-edge detection.
  always_ff @(posedge clk_12m or posedge rst) begin
    if (rst) begin
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      done_s3_q <= 1'b0;
    end else begin
      done_s1_q <= i2c_done_async;
      done_s2_q <= done_s1_q;
      done_s3_q <= done_s2_q;
    end
  end

  assign done_rise = done_s2_q & ~done_s3_q;

  always_ff @(posedge clk_12m or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      gap_q         <= '0;
      is_read_q     <= 1'b0;
      config_q      <= I2C_WAIT;
      dev_q         <= '0;
      reg_q         <= '0;
      data_q        <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      // Clear first so a same-cycle error event below overrides it.
      if (err_clr) begin
        err_timeout_q <= 1'b0;
        err_illegal_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (op_is_legal(head_op)) begin
              config_q  <= head_op;
              dev_q     <= head[DEV_LSB +: 7];
              reg_q     <= head[REG_LSB +: 8];
              data_q    <= head[DATA_LSB +: 8];
              is_read_q <= op_is_read(head_op);
              timer_q   <= '0;
              state_q   <= BUSY;
            end else begin
              err_illegal_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (done_rise) begin
            if (is_read_q) begin
              rd_data_q  <= i2c_read_data;
              rd_valid_q <= 1'b1;
            end
            config_q <= I2C_WAIT;
            gap_q    <= GW'(GAP_CYC - 1);
            state_q  <= GAP;
          end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            err_timeout_q <= 1'b1;
            config_q      <= I2C_WAIT;
            gap_q         <= GW'(GAP_CYC - 1);
            state_q       <= GAP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i2c_config   = config_q;
  assign i2c_dev_addr = dev_q;
  assign i2c_reg_addr = reg_q;
  assign i2c_reg_data = data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign busy         = (state_q != IDLE);
  assign err_timeout  = err_timeout_q;
  assign err_illegal  = err_illegal_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed-plus-random bench for i2c_cmd_sequencer: a register-file model of the
// I2C target predicts read bytes; issue order, gap spacing and timeout come from command-level rules.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned GAP_CYC     = 20;
  localparam int unsigned TIMEOUT_CYC = 100;
  localparam int unsigned WAIT_LIMIT  = GAP_CYC + 16;
  localparam int unsigned IDLE_LIMIT  = GAP_CYC + TIMEOUT_CYC + 16;

  typedef struct packed {
    logic [7:0] op;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
    logic [7:0] rd;
  } cmd_t;

  logic       clk_12m = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_op = '0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  logic       enable = 1'b0;
  logic       i2c_done_async = 1'b0;
  logic [7:0] i2c_read_data = '0;
  logic [7:0] i2c_config;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_reg_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic [3:0] fifo_count;
  logic       err_timeout;
  logic       err_illegal;
  logic       err_clr = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rdv_seen = 0;
  logic [7:0] model_mem [int];
  logic [7:0] slave_mem [int];

  always #42 clk_12m = ~clk_12m;

  always @(negedge clk_12m) if (rd_valid === 1'b1) rdv_seen++;

  i2c_cmd_sequencer #(
    .DEPTH       (DEPTH),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_12m        (clk_12m),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_dev        (cmd_dev),
    .cmd_reg        (cmd_reg),
    .cmd_data       (cmd_data),
    .enable         (enable),
    .i2c_done_async (i2c_done_async),
    .i2c_read_data  (i2c_read_data),
    .i2c_config     (i2c_config),
    .i2c_dev_addr   (i2c_dev_addr),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_reg_data   (i2c_reg_data),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .err_timeout    (err_timeout),
    .err_illegal    (err_illegal),
    .err_clr        (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_12m);
    #1;
  endtask

  function automatic logic is_rd(input logic [7:0] op);
    return (op == 8'h04) || (op == 8'h06);
  endfunction

  // Unwritten target registers read back as a fixed function of their address.
  function automatic logic [7:0] reset_val(input logic [6:0] dev, input logic [7:0] rg);
    return {dev[3:0], rg[3:0]} ^ 8'h3C;
  endfunction

  function automatic cmd_t model_issue(input cmd_t c);
    cmd_t r = c;
    int   key = int'({c.dev, c.rg});
    if (is_rd(c.op)) r.rd = model_mem.exists(key) ? model_mem[key] : reset_val(c.dev, c.rg);
    else             model_mem[key] = c.dat;
    return r;
  endfunction

  function automatic cmd_t rand_cmd(input logic [7:0] op);
    cmd_t c;
    c.op  = op;
    c.dev = 7'h50 + 7'($urandom_range(0, 1));
    c.rg  = 8'($urandom_range(0, 3));
    c.dat = 8'($urandom);
    c.rd  = '0;
    return c;
  endfunction

  function automatic logic [7:0] rand_legal_op();
    logic [7:0] ops [4] = '{8'h01, 8'h03, 8'h04, 8'h06};
    return ops[$urandom_range(0, 3)];
  endfunction

  task automatic push(input cmd_t c);
    cmd_valid = 1'b1;
    cmd_op    = c.op;
    cmd_dev   = c.dev;
    cmd_reg   = c.rg;
    cmd_data  = c.dat;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy === 1'b1 && n < IDLE_LIMIT) begin tick(1); n++; end
    check("idle_wait", 32'(n < IDLE_LIMIT), 32'd1);
  endtask

  // Acts as the I2C target: waits for issue, answers, pulses done; ends one cycle after completion.
  task automatic serve(input cmd_t c, output int unsigned wait_cyc);
    int unsigned n = 0;
    int          key = int'({c.dev, c.rg});
    while (i2c_config === 8'h00 && n < WAIT_LIMIT) begin tick(1); n++; end
    wait_cyc = n;
    check("issue_wait", 32'(n < WAIT_LIMIT), 32'd1);
    check("cfg", 32'(i2c_config), 32'(c.op));
    check("dev", 32'(i2c_dev_addr), 32'(c.dev));
    check("reg", 32'(i2c_reg_addr), 32'(c.rg));
    check("data", 32'(i2c_reg_data), 32'(c.dat));
    if (is_rd(c.op)) i2c_read_data = slave_mem.exists(key) ? slave_mem[key] : reset_val(c.dev, c.rg);
    else             slave_mem[key] = c.dat;
    tick(2);
    check("cfg_hold", 32'(i2c_config), 32'(c.op));
    i2c_done_async = 1'b1;
    n = 0;
    while (i2c_config !== 8'h00 && n < 8) begin tick(1); n++; end
    check("done_latency", 32'(n >= 1 && n <= 4), 32'd1);
    check("rd_valid", 32'(rd_valid), 32'(is_rd(c.op)));
    if (is_rd(c.op)) check("rd_data", 32'(rd_data), 32'(c.rd));
    check("dev_kept", 32'(i2c_dev_addr), 32'(c.dev));
    i2c_done_async = 1'b0;
    tick(1);
    check("rd_valid_pulse", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    cmd_t        c, c2;
    cmd_t        q [9];
    int unsigned w, n, rdv0;

    // Reset state
    tick(2);
    check("rst_cfg", 32'(i2c_config), 32'h00);
    check("rst_dev", 32'(i2c_dev_addr), 32'h00);
    check("rst_reg", 32'(i2c_reg_addr), 32'h00);
    check("rst_data", 32'(i2c_reg_data), 32'h00);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_rdd", 32'(rd_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_errs", 32'({err_timeout, err_illegal}), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick(2);

    // Single write: two-cycle issue latency, gap length
    enable = 1'b1;
    c = model_issue('{op: 8'h01, dev: 7'h50, rg: 8'h00, dat: 8'h11, rd: 8'h00});
    push(c);
    check("lat_cfg_early", 32'(i2c_config), 32'h00);
    check("lat_cnt", 32'(fifo_count), 32'd1);
    tick(1);
    check("lat_cfg", 32'(i2c_config), 32'h01);
    check("lat_busy", 32'(busy), 32'd1);
    rdv0 = rdv_seen;
    serve(c, w);
    check("wr_no_rdv", rdv_seen, rdv0);
    n = 0;
    while (busy === 1'b1 && n < WAIT_LIMIT) begin tick(1); n++; end
    // serve returned one cycle after completion, so busy should fall GAP_CYC-1 cycles later
    check("busy_gap", n + 1, GAP_CYC);

    // Write then read, queued back to back
    c  = model_issue('{op: 8'h01, dev: 7'h50, rg: 8'h00, dat: 8'h11, rd: 8'h00});
    c2 = model_issue('{op: 8'h04, dev: 7'h50, rg: 8'h00, dat: 8'($urandom), rd: 8'h00});
    push(c);
    push(c2);
    check("wr_rd_expect", 32'(c2.rd), 32'h11);
    serve(c, w);
    rdv0 = rdv_seen;
    serve(c2, w);
    // next issue lands GAP_CYC+1 edges after completion; serve already consumed one
    check("gap_spacing", w, GAP_CYC);
    check("rd_strobe_count", rdv_seen - rdv0, 32'd1);

    // Full FIFO with enable low: 9th push dropped, 8 issued in order
    wait_idle();
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      q[i] = rand_cmd(rand_legal_op());
      if (i < 8) q[i] = model_issue(q[i]);
      push(q[i]);
      if (i == 7) begin
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_cnt", 32'(fifo_count), 32'd8);
      end
    end
    check("full_drop_cnt", 32'(fifo_count), 32'd8);
    tick(3);
    check("disabled_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) serve(q[i], w);
    check("drain_cnt", 32'(fifo_count), 32'd0);

    // Illegal op dropped, following legal command issued
    wait_idle();
    c  = rand_cmd(8'h02);
    c2 = model_issue('{op: 8'h03, dev: 7'h50, rg: 8'h10, dat: 8'hAA, rd: 8'h00});
    push(c);
    push(c2);
    check("ill_flag", 32'(err_illegal), 32'd1);
    check("ill_cnt", 32'(fifo_count), 32'd1);
    serve(c2, w);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ill_clr", 32'(err_illegal), 32'd0);
    wait_idle();
    c = rand_cmd(8'($urandom_range(7, 255)));
    push(c);
    tick(1);
    check("ill2_flag", 32'(err_illegal), 32'd1);
    check("ill2_cnt", 32'(fifo_count), 32'd0);
    check("ill2_busy", 32'(busy), 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ill2_clr", 32'(err_illegal), 32'd0);

    // Timeout on a read with no done
    c = rand_cmd(($urandom_range(0, 1) == 0) ? 8'h04 : 8'h06);
    rdv0 = rdv_seen;
    push(c);
    n = 0;
    while (i2c_config === 8'h00 && n < WAIT_LIMIT) begin tick(1); n++; end
    check("to_issue", 32'(n < WAIT_LIMIT), 32'd1);
    tick(TIMEOUT_CYC - 1);
    check("to_not_yet", 32'(err_timeout), 32'd0);
    check("to_cfg_held", 32'(i2c_config), 32'(c.op));
    tick(1);
    check("to_flag", 32'(err_timeout), 32'd1);
    check("to_cfg", 32'(i2c_config), 32'h00);
    tick(2);
    check("to_no_rdv", rdv_seen, rdv0);
    c = model_issue(rand_cmd(8'h01));
    push(c);
    serve(c, w);
    check("to_sticky", 32'(err_timeout), 32'd1);

    // Reset in the middle of a read with another command queued
    wait_idle();
    c  = rand_cmd(8'h04);
    c2 = rand_cmd(8'h03);
    push(c);
    push(c2);
    tick(3);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_cnt", 32'(fifo_count), 32'd1);
    #10 rst = 1'b1;
    #1;
    check("arst_cfg", 32'(i2c_config), 32'h00);
    check("arst_addr", 32'({i2c_dev_addr, i2c_reg_addr, i2c_reg_data}), 32'h0);
    check("arst_cnt", 32'(fifo_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_errs", 32'({err_timeout, err_illegal}), 32'd0);
    tick(2);
    rst = 1'b0;
    rdv0 = rdv_seen;
    i2c_done_async = 1'b1;
    tick(6);
    i2c_done_async = 1'b0;
    tick(2);
    check("late_done_rdv", rdv_seen, rdv0);
    check("late_done_cfg", 32'(i2c_config), 32'h00);
    check("late_done_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
